calib_fsm: RTL and testbench

Calibration sequencer for the light-tracker servo path. On START it runs a horizontal sweep, then a vertical sweep, by driving the sweep-enable lines of the horizontal and vertical max counters. During each sweep it tracks the LIGHT sensor reading and records the sweep step with the highest light level. It sits directly upstream of the horizontal/vertical counters, and its BEST_H/BEST_V results feed the servo positioning logic.

---
 rtl/calib_fsm.sv | 117 +++++++++++
 tb/tb_calib_fsm.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/calib_fsm.sv
// calib_fsm: two-axis light-peak calibration sequencer driving the H/V sweep counters,
// recording the sweep step with the strictly highest LIGHT sample on each axis.
module calib_fsm #(
  parameter int LW  = 10,
  parameter int PW  = 9,
  parameter int TMO = 1024
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          CNT_L,
  input  logic          CNT_U,
  input  logic [LW-1:0] LIGHT,
  output logic          HS,
  output logic          VS,
  output logic          BUSY,
  output logic          DONE,
  output logic          VALID,
  output logic          ERR,
  output logic [PW-1:0] BEST_H,
  output logic [PW-1:0] BEST_V,
  output logic [LW-1:0] MAX_LIGHT
);
  localparam int TW = $clog2(TMO);
  localparam logic [TW-1:0] TLAST = TW'(TMO - 1);
  typedef enum logic [2:0] {IDLE, H_ARM, H_SWEEP, H_CLR, V_ARM, V_SWEEP, V_CLR, FIN} state_t;
  state_t        st;
  logic [LW-1:0] mx;
  logic [PW-1:0] pos;
  logic [TW-1:0] tmr;
  logic          hor, arm, cnt, leave;
  always_comb begin
    hor   = st == H_ARM || st == H_SWEEP;
    arm   = st == H_ARM || st == V_ARM;
    cnt   = hor ? CNT_L : CNT_U;
    leave = arm ? cnt : !cnt;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st        <= IDLE;
      HS        <= 1'b0;
      VS        <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      VALID     <= 1'b0;
      ERR       <= 1'b0;
      BEST_H    <= '0;
      BEST_V    <= '0;
      MAX_LIGHT <= '0;
      mx        <= '0;
      pos       <= '0;
      tmr       <= '0;
    end else begin
      DONE <= 1'b0;
      case (st)
        IDLE: if (START) begin
          st     <= H_ARM;
          HS     <= 1'b1;
          BUSY   <= 1'b1;
          ERR    <= 1'b0;
          VALID  <= 1'b0;
          BEST_H <= '0;
          BEST_V <= '0;
          mx     <= '0;
          pos    <= '0;
          tmr    <= '0;
        end
        H_ARM, H_SWEEP, V_ARM, V_SWEEP: begin
          // the first busy cycle, seen while still armed, is step 0
          if (cnt) begin
            if (LIGHT > mx) begin
              mx <= LIGHT;
              if (hor) BEST_H <= pos;
              else BEST_V <= pos;
            end
            pos <= &pos ? pos : pos + 1'b1;
          end
          if (leave) begin
            st <= arm ? (hor ? H_SWEEP : V_SWEEP) : (hor ? H_CLR : V_CLR);
            if (!arm) begin
              HS <= 1'b0;
              VS <= 1'b0;
            end
          end else if (tmr == TLAST) begin
            st   <= IDLE;
            HS   <= 1'b0;
            VS   <= 1'b0;
            BUSY <= 1'b0;
            ERR  <= 1'b1;
          end else tmr <= tmr + 1'b1;
        end
        H_CLR: begin
          st        <= V_ARM;
          VS        <= 1'b1;
          MAX_LIGHT <= mx;
          mx        <= '0;
          pos       <= '0;
          tmr       <= '0;
        end
        V_CLR: begin
          st        <= FIN;
          DONE      <= 1'b1;
          VALID     <= 1'b1;
          MAX_LIGHT <= mx;
          mx        <= '0;
          pos       <= '0;
          tmr       <= '0;
        end
        FIN: begin
          st   <= IDLE;
          BUSY <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calib_fsm.sv
// tb_calib_fsm: drives calib_fsm with behavioural 511-step H/V counters and checks peak
// search, timing, timeout, async reset and restart against a reference model.
module tb_calib_fsm;
  localparam int LW = 10, PW = 9, TMO = 1024, STEPS = 511;
  // one edge for the counter to see the enable, one for the FSM to see busy
  localparam int ARM_CYC = 2;
  localparam int LAT = 2 * (ARM_CYC + STEPS + 1) + 1;
  logic CLK = 1'b0, RST_N, START, CNT_L, CNT_U;
  logic [LW-1:0] LIGHT;
  logic HS, VS, BUSY, DONE, VALID, ERR;
  logic [PW-1:0] BEST_H, BEST_V;
  logic [LW-1:0] MAX_LIGHT;
  logic [8:0] hc, vc;
  logic cl, cu, kill_l;
  logic [LW-1:0] hl [512], vl [512], idle_l;
  int checks = 0, errors = 0;
  typedef struct {int base, hi, hv, vi, vv, bh, bv, mx;} vec_t;
  vec_t tv [4];
  calib_fsm dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .CNT_L(CNT_L), .CNT_U(CNT_U), .LIGHT(LIGHT),
    .HS(HS), .VS(VS), .BUSY(BUSY), .DONE(DONE), .VALID(VALID), .ERR(ERR),
    .BEST_H(BEST_H), .BEST_V(BEST_V), .MAX_LIGHT(MAX_LIGHT)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK or negedge RST_N)
    if (!RST_N || !HS) begin hc <= '0; cl <= 1'b0; end
    else if (hc < 9'(STEPS)) begin hc <= hc + 9'd1; cl <= 1'b1; end
    else cl <= 1'b0;
  always @(posedge CLK or negedge RST_N)
    if (!RST_N || !VS) begin vc <= '0; cu <= 1'b0; end
    else if (vc < 9'(STEPS)) begin vc <= vc + 9'd1; cu <= 1'b1; end
    else cu <= 1'b0;
  assign CNT_L = cl & ~kill_l;
  assign CNT_U = cu;
  always_comb LIGHT = CNT_L ? hl[hc - 9'd1] : CNT_U ? vl[vc - 9'd1] : idle_l;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input int base, input int hi, input int hv, input int vi, input int vv);
    for (int i = 0; i < 512; i++) begin hl[i] = LW'(base); vl[i] = LW'(base); end
    hl[hi] = LW'(hv);
    vl[vi] = LW'(vv);
  endtask

  // peak value per axis, then the first step that reaches it; an all-zero axis reports 0
  task automatic model(output int bh, output int bv, output int mx);
    int hm, vm;
    hm = 0; vm = 0; bh = 0; bv = 0;
    for (int i = 0; i < STEPS; i++) begin
      if (int'(hl[i]) > hm) hm = int'(hl[i]);
      if (int'(vl[i]) > vm) vm = int'(vl[i]);
    end
    for (int i = STEPS - 1; i >= 0; i--) begin
      if (hm > 0 && int'(hl[i]) == hm) bh = i;
      if (vm > 0 && int'(vl[i]) == vm) bv = i;
    end
    mx = vm;
  endtask

  task automatic do_run(input string tag, input int ebh, input int ebv, input int emx, input bit poke);
    int n;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    chk({tag, " busy@arm"}, BUSY, 1);
    chk({tag, " hs@arm"}, HS, 1);
    chk({tag, " valid@arm"}, VALID, 0);
    chk({tag, " err@arm"}, ERR, 0);
    n = 1;
    while (!DONE && n < 3 * LAT) begin
      @(negedge CLK); n++;
      START = poke && CNT_U && vc == 9'd51;
    end
    START = 1'b0;
    chk({tag, " done latency"}, n, LAT);
    chk({tag, " best_h"}, BEST_H, ebh);
    chk({tag, " best_v"}, BEST_V, ebv);
    chk({tag, " max_light"}, MAX_LIGHT, emx);
    chk({tag, " valid"}, VALID, 1);
    chk({tag, " err"}, ERR, 0);
    @(negedge CLK);
    chk({tag, " done width"}, DONE, 0);
    chk({tag, " idle after"}, BUSY, 0);
  endtask

  initial begin
    int bh, bv, mx, k, dones;
    tv[0] = '{100, 37, 700, 402, 650, 37, 402, 650};
    tv[1] = '{5, 0, 1023, 510, 1023, 0, 510, 1023};
    tv[2] = '{0, 300, 0, 1, 1, 0, 1, 1};
    tv[3] = '{1023, 5, 1023, 6, 1023, 0, 0, 1023};
    RST_N = 1'b0; START = 1'b0; kill_l = 1'b0; idle_l = 10'd1023;
    fill(100, 37, 700, 402, 650);
    #12;
    chk("reset outs", {HS, VS, BUSY, DONE, VALID, ERR}, 0);
    chk("reset results", {BEST_H, BEST_V, MAX_LIGHT}, 0);
    @(negedge CLK); RST_N = 1'b1;
    foreach (tv[i]) begin
      fill(tv[i].base, tv[i].hi, tv[i].hv, tv[i].vi, tv[i].vv);
      do_run($sformatf("vec%0d", i), tv[i].bh, tv[i].bv, tv[i].mx, 1'b0);
    end
    fill(0, 10, 500, 0, 0);
    hl[20] = 10'd500;
    do_run("tie", 10, 0, 0, 1'b0);
    fill(100, 37, 700, 402, 650);
    do_run("start while busy", 37, 402, 650, 1'b1);
    kill_l = 1'b1;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    k = 0; dones = 0;
    while (BUSY && !ERR && k < 3 * TMO) begin
      k++; dones += int'(DONE);
      @(negedge CLK);
    end
    chk("timeout arm cycles", k, TMO);
    chk("timeout err", ERR, 1);
    chk("timeout hs", HS, 0);
    chk("timeout busy", BUSY, 0);
    chk("timeout valid", VALID, 0);
    chk("timeout no done", dones + int'(DONE), 0);
    kill_l = 1'b0;
    do_run("after timeout", 37, 402, 650, 1'b0);
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    k = 0;
    while (!(CNT_L && hc == 9'd201) && k < 2000) begin @(negedge CLK); k++; end
    chk("reach h step 200", k < 2000, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("async rst outs", {HS, VS, BUSY, DONE, VALID, ERR}, 0);
    chk("async rst results", {BEST_H, BEST_V, MAX_LIGHT}, 0);
    @(negedge CLK); RST_N = 1'b1;
    do_run("after reset", 37, 402, 650, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 512; i++) begin
        hl[i] = LW'($urandom_range(0, 1023));
        vl[i] = LW'($urandom_range(0, 1023));
      end
      model(bh, bv, mx);
      do_run($sformatf("rand%0d", r), bh, bv, mx, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
